// File: rtl/ibex_rf_writeback.sv
// ibex_rf_writeback: writeback stage in front of the register file write port.
// Merges execute results with in-order load responses into one registered
// write. Tracks outstanding load destinations and flags RAW/WAW hazards to ID.
module ibex_rf_writeback #(
    parameter int DataWidth = 32,
    parameter bit RV32E     = 1'b0,
    parameter int LoadDepth = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           ex_we_i,
    input  logic [4:0]                     ex_waddr_i,
    input  logic [DataWidth-1:0]           ex_wdata_i,
    output logic                           ex_ready_o,
    input  logic                           lsu_req_i,
    input  logic [4:0]                     lsu_req_waddr_i,
    output logic                           lsu_req_ready_o,
    input  logic                           lsu_resp_valid_i,
    input  logic [DataWidth-1:0]           lsu_resp_rdata_i,
    input  logic                           lsu_resp_err_i,
    input  logic [4:0]                     raddr_a_i,
    input  logic [4:0]                     raddr_b_i,
    output logic                           stall_raw_o,
    output logic                           rf_we_o,
    output logic [4:0]                     rf_waddr_o,
    output logic [DataWidth-1:0]           rf_wdata_o,
    output logic [$clog2(LoadDepth+1)-1:0] pending_o,
    output logic                           err_o
);

    localparam int PtrW = (LoadDepth > 1) ? $clog2(LoadDepth) : 1;
    localparam int CntW = $clog2(LoadDepth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(LoadDepth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(LoadDepth);

    // Load destination queue: per-slot address plus valid bit, so the hazard
    // compare only has to look at occupied slots.
    logic [4:0]           q_addr [LoadDepth];
    logic [LoadDepth-1:0] q_vld;
    logic [PtrW-1:0]      wptr;
    logic [PtrW-1:0]      rptr;
    logic [CntW-1:0]      count;

    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 hit_ex;
    logic                 hit_a;
    logic                 hit_b;
    logic                 win_vld;
    logic [4:0]           win_addr;
    logic [DataWidth-1:0] win_data;
    logic                 illegal;
    logic                 wr;
    logic                 err_next;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Queue handshakes; a response can always free a slot for a same-cycle push
    always_comb begin
        empty           = (count == '0);
        pop             = lsu_resp_valid_i && !empty;
        lsu_req_ready_o = (count < FullCnt) || lsu_resp_valid_i;
        push            = lsu_req_i && lsu_req_ready_o;
    end

    // Compare execute destination and both read ports against queued loads
    always_comb begin
        hit_ex = 1'b0;
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        for (int i = 0; i < LoadDepth; i++) begin
            if (q_vld[i] && q_addr[i] == ex_waddr_i) hit_ex = 1'b1;
            if (q_vld[i] && q_addr[i] == raddr_a_i)  hit_a  = 1'b1;
            if (q_vld[i] && q_addr[i] == raddr_b_i)  hit_b  = 1'b1;
        end
    end

    // Execute is held while a load response owns the port or an older load
    // still targets the same register (WAW ordering)
    always_comb begin
        ex_ready_o  = !lsu_resp_valid_i && !(ex_we_i && ex_waddr_i != 5'd0 && hit_ex);
        stall_raw_o = (raddr_a_i != 5'd0 && (hit_a || (rf_we_o && rf_waddr_o == raddr_a_i))) ||
                      (raddr_b_i != 5'd0 && (hit_b || (rf_we_o && rf_waddr_o == raddr_b_i)));
        pending_o   = count;
    end

    // Winner select: load response first; erroring loads and x0 never write
    always_comb begin
        if (lsu_resp_valid_i) begin
            win_vld  = pop && !lsu_resp_err_i;
            win_addr = q_addr[rptr];
            win_data = lsu_resp_rdata_i;
        end else begin
            win_vld  = ex_we_i && ex_ready_o;
            win_addr = ex_waddr_i;
            win_data = ex_wdata_i;
        end
        illegal  = RV32E && win_vld && win_addr[4];
        wr       = win_vld && win_addr != 5'd0 && !illegal;
        err_next = (lsu_resp_valid_i && empty) || (lsu_req_i && !lsu_req_ready_o) || illegal;
    end

    // Queue control state; pop before push so a full queue can turn over a slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            q_vld <= '0;
        end else begin
            if (pop) begin
                rptr        <= ptr_inc(rptr);
                q_vld[rptr] <= 1'b0;
            end
            if (push) begin
                wptr        <= ptr_inc(wptr);
                q_vld[wptr] <= 1'b1;
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Queue payload needs no reset; it is qualified by q_vld
    always_ff @(posedge clk_i) begin
        if (push) q_addr[wptr] <= lsu_req_waddr_i;
    end

    // Registered write port; address and data only move on a real write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            err_o      <= 1'b0;
        end else begin
            rf_we_o <= wr;
            err_o   <= err_next;
            if (wr) begin
                rf_waddr_o <= win_addr;
                rf_wdata_o <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_ibex_rf_writeback.sv
// Directed bench for ibex_rf_writeback: a cycle-by-cycle vector table applied
// to an RV32I and an RV32E instance, plus hand sequences for RV32E and reset.
module tb_ibex_rf_writeback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_we = 1'b0;
    logic [4:0]  ex_waddr = '0;
    logic [31:0] ex_wdata = '0;
    logic        req = 1'b0;
    logic [4:0]  req_waddr = '0;
    logic        resp_v = 1'b0;
    logic [31:0] rdata = '0;
    logic        resp_err = 1'b0;
    logic [4:0]  raddr_a = '0;
    logic [4:0]  raddr_b = '0;

    logic        ex_ready, req_ready, stall, rf_we, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  pending;
    logic        ex_ready_e, req_ready_e, stall_e, rf_we_e, err_e;
    logic [4:0]  rf_waddr_e;
    logic [31:0] rf_wdata_e;
    logic [1:0]  pending_e;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_rf_writeback #(.DataWidth(32), .RV32E(1'b0), .LoadDepth(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
        .lsu_req_i(req), .lsu_req_waddr_i(req_waddr), .lsu_req_ready_o(req_ready),
        .lsu_resp_valid_i(resp_v), .lsu_resp_rdata_i(rdata), .lsu_resp_err_i(resp_err),
        .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .stall_raw_o(stall),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .pending_o(pending), .err_o(err)
    );

    ibex_rf_writeback #(.DataWidth(32), .RV32E(1'b1), .LoadDepth(2)) dut_e (
        .clk_i(clk), .rst_ni(rst_n),
        .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready_e),
        .lsu_req_i(req), .lsu_req_waddr_i(req_waddr), .lsu_req_ready_o(req_ready_e),
        .lsu_resp_valid_i(resp_v), .lsu_resp_rdata_i(rdata), .lsu_resp_err_i(resp_err),
        .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .stall_raw_o(stall_e),
        .rf_we_o(rf_we_e), .rf_waddr_o(rf_waddr_e), .rf_wdata_o(rf_wdata_e),
        .pending_o(pending_e), .err_o(err_e)
    );

    typedef struct {
        logic        ex_we;
        logic [4:0]  ex_waddr;
        logic [31:0] ex_wdata;
        logic        req;
        logic [4:0]  req_waddr;
        logic        resp_v;
        logic [31:0] rdata;
        logic        resp_err;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        x_exr;
        logic        x_reqr;
        logic        x_stall;
        logic        x_we;
        logic [4:0]  x_waddr;
        logic [31:0] x_wdata;
        logic [1:0]  x_pend;
        logic        x_err;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic a_we, input logic [4:0] a_wa, input logic [31:0] a_wd,
        input logic a_rq, input logic [4:0] a_rqa,
        input logic a_rv, input logic [31:0] a_rd, input logic a_re,
        input logic [4:0] a_ra, input logic [4:0] a_rb,
        input logic e_exr, input logic e_reqr, input logic e_st,
        input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic [1:0] e_p, input logic e_er);
        vec_t v;
        v.ex_we = a_we; v.ex_waddr = a_wa; v.ex_wdata = a_wd;
        v.req = a_rq; v.req_waddr = a_rqa;
        v.resp_v = a_rv; v.rdata = a_rd; v.resp_err = a_re;
        v.ra = a_ra; v.rb = a_rb;
        v.x_exr = e_exr; v.x_reqr = e_reqr; v.x_stall = e_st;
        v.x_we = e_we; v.x_waddr = e_wa; v.x_wdata = e_wd; v.x_pend = e_p; v.x_err = e_er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0;
        req = 1'b0; req_waddr = '0;
        resp_v = 1'b0; rdata = '0; resp_err = 1'b0;
        raddr_a = '0; raddr_b = '0;
    endtask

    task automatic chk_regs_both(input string tag, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic [1:0] p, input logic er);
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(we));
        chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(wa));
        chk({tag, ".rf_wdata"}, rf_wdata, wd);
        chk({tag, ".pending"}, 32'(pending), 32'(p));
        chk({tag, ".err"}, 32'(err), 32'(er));
        chk({tag, ".e_rf_we"}, 32'(rf_we_e), 32'(we));
        chk({tag, ".e_rf_waddr"}, 32'(rf_waddr_e), 32'(wa));
        chk({tag, ".e_rf_wdata"}, rf_wdata_e, wd);
        chk({tag, ".e_pending"}, 32'(pending_e), 32'(p));
        chk({tag, ".e_err"}, 32'(err_e), 32'(er));
    endtask

    initial begin
        // columns: ex_we ex_waddr ex_wdata | req req_waddr | resp_v rdata err | ra rb |
        //          exp ex_ready req_ready stall | exp rf_we waddr wdata pending err (after edge)
        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0,  0, 0, 0,        0, 0, 1, 1, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        vecs[1]  = mk(0, 0, 0,            0, 0,  0, 0, 0,        0, 0, 1, 1, 0, 0, 5, 32'hDEADBEEF, 0, 0);
        vecs[2]  = mk(0, 0, 0,            1, 7,  0, 0, 0,        0, 0, 1, 1, 0, 0, 5, 32'hDEADBEEF, 1, 0);
        vecs[3]  = mk(0, 0, 0,            1, 9,  0, 0, 0,        9, 0, 1, 1, 0, 0, 5, 32'hDEADBEEF, 2, 0);
        vecs[4]  = mk(0, 0, 0,            1, 12, 0, 0, 0,        9, 0, 1, 0, 1, 0, 5, 32'hDEADBEEF, 2, 1);
        vecs[5]  = mk(0, 0, 0,            0, 0,  1, 32'h11, 0,   9, 0, 0, 1, 1, 1, 7, 32'h11, 1, 0);
        vecs[6]  = mk(0, 0, 0,            0, 0,  1, 32'h22, 0,   9, 0, 0, 1, 1, 1, 9, 32'h22, 0, 0);
        vecs[7]  = mk(0, 0, 0,            0, 0,  0, 0, 0,        9, 0, 1, 1, 1, 0, 9, 32'h22, 0, 0);
        vecs[8]  = mk(0, 0, 0,            0, 0,  0, 0, 0,        9, 0, 1, 1, 0, 0, 9, 32'h22, 0, 0);
        vecs[9]  = mk(0, 0, 0,            1, 3,  0, 0, 0,        0, 0, 1, 1, 0, 0, 9, 32'h22, 1, 0);
        vecs[10] = mk(1, 4, 32'h44,       0, 0,  1, 32'h33, 0,   0, 0, 0, 1, 0, 1, 3, 32'h33, 0, 0);
        vecs[11] = mk(1, 4, 32'h44,       0, 0,  0, 0, 0,        0, 0, 1, 1, 0, 1, 4, 32'h44, 0, 0);
        vecs[12] = mk(0, 0, 0,            1, 6,  0, 0, 0,        0, 0, 1, 1, 0, 0, 4, 32'h44, 1, 0);
        vecs[13] = mk(1, 6, 32'h66,       0, 0,  0, 0, 0,        0, 6, 0, 1, 1, 0, 4, 32'h44, 1, 0);
        vecs[14] = mk(1, 6, 32'h66,       0, 0,  1, 32'h60, 0,   0, 6, 0, 1, 1, 1, 6, 32'h60, 0, 0);
        vecs[15] = mk(1, 6, 32'h66,       0, 0,  0, 0, 0,        0, 6, 1, 1, 1, 1, 6, 32'h66, 0, 0);
        vecs[16] = mk(0, 0, 0,            0, 0,  0, 0, 0,        0, 6, 1, 1, 1, 0, 6, 32'h66, 0, 0);
        vecs[17] = mk(1, 0, 32'h77,       0, 0,  0, 0, 0,        0, 0, 1, 1, 0, 0, 6, 32'h66, 0, 0);
        vecs[18] = mk(0, 0, 0,            1, 8,  0, 0, 0,        0, 0, 1, 1, 0, 0, 6, 32'h66, 1, 0);
        vecs[19] = mk(0, 0, 0,            0, 0,  1, 32'h88, 1,   0, 0, 0, 1, 0, 0, 6, 32'h66, 0, 0);
        vecs[20] = mk(0, 0, 0,            0, 0,  1, 32'h99, 0,   0, 0, 0, 1, 0, 0, 6, 32'h66, 0, 1);
        vecs[21] = mk(0, 0, 0,            0, 0,  0, 0, 0,        0, 0, 1, 1, 0, 0, 6, 32'h66, 0, 0);
        vecs[22] = mk(0, 0, 0,            1, 0,  0, 0, 0,        0, 0, 1, 1, 0, 0, 6, 32'h66, 1, 0);
        vecs[23] = mk(0, 0, 0,            0, 0,  1, 32'h55, 0,   0, 0, 0, 1, 0, 0, 6, 32'h66, 0, 0);
        vecs[24] = mk(0, 0, 0,            1, 1,  0, 0, 0,        0, 0, 1, 1, 0, 0, 6, 32'h66, 1, 0);
        vecs[25] = mk(0, 0, 0,            1, 2,  0, 0, 0,        0, 0, 1, 1, 0, 0, 6, 32'h66, 2, 0);
        vecs[26] = mk(0, 0, 0,            1, 10, 1, 32'hAA, 0,   0, 0, 0, 1, 0, 1, 1, 32'hAA, 2, 0);
        vecs[27] = mk(0, 0, 0,            0, 0,  1, 32'hBB, 0,  10, 0, 0, 1, 1, 1, 2, 32'hBB, 1, 0);
        vecs[28] = mk(0, 0, 0,            0, 0,  1, 32'hCC, 0,  10, 0, 0, 1, 1, 1, 10, 32'hCC, 0, 0);

        // Reset state
        idle();
        rst_n = 1'b0;
        repeat (2) tick();
        chk_regs_both("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven cycles
        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            ex_we = vecs[i].ex_we; ex_waddr = vecs[i].ex_waddr; ex_wdata = vecs[i].ex_wdata;
            req = vecs[i].req; req_waddr = vecs[i].req_waddr;
            resp_v = vecs[i].resp_v; rdata = vecs[i].rdata; resp_err = vecs[i].resp_err;
            raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
            #1;
            chk({tag, ".ex_ready"}, 32'(ex_ready), 32'(vecs[i].x_exr));
            chk({tag, ".req_ready"}, 32'(req_ready), 32'(vecs[i].x_reqr));
            chk({tag, ".stall"}, 32'(stall), 32'(vecs[i].x_stall));
            chk({tag, ".e_stall"}, 32'(stall_e), 32'(vecs[i].x_stall));
            tick();
            chk_regs_both(tag, vecs[i].x_we, vecs[i].x_waddr, vecs[i].x_wdata,
                          vecs[i].x_pend, vecs[i].x_err);
        end

        // RV32E: execute write to x20 is illegal only in the RV32E instance
        idle();
        ex_we = 1'b1; ex_waddr = 5'd20; ex_wdata = 32'h1234;
        #1;
        chk("e20.ex_ready", 32'(ex_ready), 32'd1);
        chk("e20.e_ex_ready", 32'(ex_ready_e), 32'd1);
        tick();
        chk("e20.rf_we", 32'(rf_we), 32'd1);
        chk("e20.rf_waddr", 32'(rf_waddr), 32'd20);
        chk("e20.rf_wdata", rf_wdata, 32'h1234);
        chk("e20.err", 32'(err), 32'd0);
        chk("e20.e_rf_we", 32'(rf_we_e), 32'd0);
        chk("e20.e_rf_waddr", 32'(rf_waddr_e), 32'd10);
        chk("e20.e_err", 32'(err_e), 32'd1);
        idle();
        tick();
        chk("e20b.e_err", 32'(err_e), 32'd0);
        chk("e20b.rf_we", 32'(rf_we), 32'd0);

        // RV32E: load to x17 is also illegal on response
        req = 1'b1; req_waddr = 5'd17;
        tick();
        idle();
        resp_v = 1'b1; rdata = 32'h5;
        tick();
        idle();
        chk("e17.rf_we", 32'(rf_we), 32'd1);
        chk("e17.rf_waddr", 32'(rf_waddr), 32'd17);
        chk("e17.err", 32'(err), 32'd0);
        chk("e17.e_rf_we", 32'(rf_we_e), 32'd0);
        chk("e17.e_err", 32'(err_e), 32'd1);
        chk("e17.e_pending", 32'(pending_e), 32'd0);

        // Reset with two loads pending and a write in the output register
        req = 1'b1; req_waddr = 5'd1;
        tick();
        req = 1'b1; req_waddr = 5'd2; ex_we = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h3;
        tick();
        idle();
        chk("prerst.pending", 32'(pending), 32'd2);
        chk("prerst.rf_we", 32'(rf_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_regs_both("midrst", 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        raddr_a = 5'd2;
        raddr_b = 5'd1;
        #1;
        chk("postrst.stall", 32'(stall), 32'd0);
        chk("postrst.e_stall", 32'(stall_e), 32'd0);
        tick();
        chk("postrst.pending", 32'(pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
